// File: rtl/pixel_byte_packer.sv
// Packs strobed input bytes into BYTES_PER_PX-byte pixels and buffers them in a show-ahead FIFO.
// Optional: define PX_PACKER_MSB_FIRST_EN to place the first byte of each pixel in the MSB slot.
module pixel_byte_packer #(
    parameter int BYTES_PER_PX = 3,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic [7:0]                        byte_i,
    input  logic                              byte_valid_i,
    input  logic                              frame_start_i,
    output logic [8*BYTES_PER_PX-1:0]         px_o,
    output logic                              px_valid_o,
    input  logic                              px_ready_i,
    output logic                              fifo_full_o,
    output logic [$clog2(FIFO_DEPTH):0]       level_o,
    output logic                              overflow_o
);
    localparam int PW   = 8 * BYTES_PER_PX;
    localparam int PH_W = $clog2(BYTES_PER_PX);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int LW   = AW + 1;
    localparam logic [PH_W-1:0] PH_LAST  = PH_W'(BYTES_PER_PX - 1);
    localparam logic [LW-1:0]   LVL_FULL = LW'(FIFO_DEPTH);

    logic [PH_W-1:0] r_ph;
    logic [PW-1:0]   r_asm;
    logic            r_ovf;
    logic [PW-1:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [LW-1:0]   r_level;

    logic [PH_W-1:0] w_slot_cur;
    logic [PH_W-1:0] w_slot0;
    logic [PW-1:0]   w_px;
    logic [PW-1:0]   w_asm_fs;
    logic            w_full;
    logic            w_last;
    logic            w_pop;
    logic            w_push;
    logic            w_drop;

`ifdef PX_PACKER_MSB_FIRST_EN
    assign w_slot_cur = PH_LAST - r_ph;
    assign w_slot0    = PH_LAST;
`else
    assign w_slot_cur = r_ph;
    assign w_slot0    = '0;
`endif

    // Pixel as it would look with the current byte merged into its slot.
    always_comb begin
        w_px = r_asm;
        w_px[8*w_slot_cur +: 8] = byte_i;
    end

    // Frame start restarts assembly; a same-cycle byte becomes phase 0.
    always_comb begin
        w_asm_fs = '0;
        if (byte_valid_i)
            w_asm_fs[8*w_slot0 +: 8] = byte_i;
    end

    assign w_full = (r_level == LVL_FULL);
    assign w_last = byte_valid_i && !frame_start_i && (r_ph == PH_LAST);
    assign w_pop  = (r_level != '0) && px_ready_i;
    assign w_push = w_last && (!w_full || w_pop);
    assign w_drop = w_last && !w_push;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_ph  <= '0;
            r_asm <= '0;
            r_ovf <= 1'b0;
        end else begin
            if (frame_start_i) begin
                r_ph  <= byte_valid_i ? PH_W'(1) : '0;
                r_asm <= w_asm_fs;
            end else if (byte_valid_i) begin
                if (r_ph == PH_LAST) begin
                    r_ph  <= '0;
                    r_asm <= '0;
                end else begin
                    r_ph  <= r_ph + PH_W'(1);
                    r_asm <= w_px;
                end
            end
            if (frame_start_i)
                r_ovf <= 1'b0;
            else if (w_drop)
                r_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < FIFO_DEPTH; i++)
                r_mem[i] <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= w_px;
                r_wptr        <= r_wptr + AW'(1);
            end
            if (w_pop)
                r_rptr <= r_rptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    assign px_o        = r_mem[r_rptr];
    assign px_valid_o  = (r_level != '0);
    assign fifo_full_o = w_full;
    assign level_o     = r_level;
    assign overflow_o  = r_ovf;
endmodule
